// File: rtl/maxnet_ctrl_pkg.sv
// Shared state encoding and default parameters for the Maxnet sequencing controller.
package maxnet_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        FIRST  = 3'd2,
        ITER   = 3'd3,
        WAIT   = 3'd4,
        CHECK  = 3'd5,
        FINISH = 3'd6
    } state_t;

    localparam int DEF_PU_LATENCY = 2;
    localparam int DEF_ITER_W     = 8;
    localparam int DEF_MAX_ITER   = 100;
    localparam int TMR_W          = 4;

endpackage

// File: rtl/maxnet_wait_timer.sv
// Loadable down-counter with zero flag; times the PU settling window.
module maxnet_wait_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/maxnet_ctrl.sv
// Maxnet sequencing controller: memory iteration, feedback iterations, convergence check.
// Define MAXNET_CTRL_TIMEOUT_EN to end a run at MAX_ITER iterations with timeout set.
module maxnet_ctrl
    import maxnet_ctrl_pkg::*;
#(
    parameter int PU_LATENCY = DEF_PU_LATENCY,
    parameter int ITER_W     = DEF_ITER_W,
    parameter int MAX_ITER   = DEF_MAX_ITER
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              done,
    output logic              sel_a,
    output logic              mem_en,
    output logic              result_signal,
    output logic              ready_sig,
    output logic              busy,
    output logic              finish,
    output logic              converged,
    output logic              timeout,
    output logic [ITER_W-1:0] iter_count
);

`ifdef MAXNET_CTRL_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    state_t state, state_nx;
    logic   wt_load, wt_dec, wt_zero, cap_hit;
    logic   sel_a_nx, mem_en_nx, result_nx, ready_nx, busy_nx, finish_nx;

    assign cap_hit = TIMEOUT_EN && (iter_count >= ITER_W'(MAX_ITER));
    assign wt_load = (state == FIRST) || (state == ITER);
    assign wt_dec  = (state == WAIT);

    maxnet_wait_timer #(.W(TMR_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (wt_load),
        .load_val (TMR_W'(PU_LATENCY - 1)),
        .dec      (wt_dec),
        .zero     (wt_zero)
    );

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = LOAD;
            LOAD:    state_nx = FIRST;
            FIRST:   state_nx = WAIT;
            ITER:    state_nx = WAIT;
            WAIT:    if (wt_zero) state_nx = CHECK;
            CHECK:   state_nx = (done || cap_hit) ? FINISH : ITER;
            FINISH:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registers line up with the state they describe.
    always_comb begin
        sel_a_nx  = 1'b0;
        mem_en_nx = 1'b0;
        result_nx = 1'b0;
        ready_nx  = 1'b0;
        busy_nx   = 1'b0;
        finish_nx = 1'b0;
        case (state_nx)
            LOAD: begin
                sel_a_nx  = 1'b1;
                mem_en_nx = 1'b1;
                ready_nx  = 1'b1;
                busy_nx   = 1'b1;
            end
            FIRST: begin
                sel_a_nx  = 1'b1;
                mem_en_nx = 1'b1;
                result_nx = 1'b1;
                busy_nx   = 1'b1;
            end
            ITER: begin
                result_nx = 1'b1;
                busy_nx   = 1'b1;
            end
            WAIT: begin
                // Keep the issuing state's input selection while the PU settles.
                sel_a_nx  = sel_a;
                mem_en_nx = mem_en;
                busy_nx   = 1'b1;
            end
            CHECK:   busy_nx   = 1'b1;
            FINISH:  finish_nx = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            sel_a         <= 1'b0;
            mem_en        <= 1'b0;
            result_signal <= 1'b0;
            ready_sig     <= 1'b0;
            busy          <= 1'b0;
            finish        <= 1'b0;
            converged     <= 1'b0;
            timeout       <= 1'b0;
            iter_count    <= '0;
        end else begin
            state         <= state_nx;
            sel_a         <= sel_a_nx;
            mem_en        <= mem_en_nx;
            result_signal <= result_nx;
            ready_sig     <= ready_nx;
            busy          <= busy_nx;
            finish        <= finish_nx;
            if (state == IDLE && start) begin
                converged  <= 1'b0;
                timeout    <= 1'b0;
                iter_count <= '0;
            end
            if (state_nx == FIRST) begin
                iter_count <= ITER_W'(1);
            end else if (state_nx == ITER && iter_count != '1) begin
                iter_count <= iter_count + ITER_W'(1);
            end
            if (state == CHECK) begin
                if (done) converged <= 1'b1;
                else if (cap_hit) timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_maxnet_ctrl.sv
// Randomized bench for maxnet_ctrl against a cycle-arithmetic model of a run.
module tb_maxnet_ctrl;

    localparam int L   = 2;
    localparam int CAP = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       done = 1'b0;
    logic       sel_a, mem_en, result_signal, ready_sig, busy, finish, converged, timeout;
    logic [7:0] iter_count;

    int   n_chk  = 0;
    int   n_pass = 0;
    logic h_conv = 1'b0;
    logic h_to   = 1'b0;
    int   h_cnt  = 0;

    maxnet_ctrl #(.PU_LATENCY(L), .ITER_W(8), .MAX_ITER(CAP)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .done          (done),
        .sel_a         (sel_a),
        .mem_en        (mem_en),
        .result_signal (result_signal),
        .ready_sig     (ready_sig),
        .busy          (busy),
        .finish        (finish),
        .converged     (converged),
        .timeout       (timeout),
        .iter_count    (iter_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [7:0] outs();
        return {sel_a, mem_en, result_signal, ready_sig, busy, finish, converged, timeout};
    endfunction

    // One run: the k-th CHECK sees done=1. Cycle t=0 is the cycle start is driven.
    // Returns early (without finishing) when stop_t is reached.
    task automatic run(input int id, input int k, input int stop_t, input bit glitch);
        int         iters, fin_t, u, n, p;
        bit         conv, to, first, is_chk;
        logic [7:0] exp_o;
        int         exp_cnt;
        iters = k;
        conv  = 1'b1;
        to    = 1'b0;
`ifdef MAXNET_CTRL_TIMEOUT_EN
        if (k > CAP) begin
            iters = CAP;
            conv  = 1'b0;
            to    = 1'b1;
        end
`endif
        fin_t = 2 + iters * (L + 2);
        for (int t = 0; t <= fin_t; t++) begin
            if (stop_t > 0 && t == stop_t) return;
            is_chk = 1'b0;
            n      = 0;
            if (t == 0) begin
                exp_o   = {6'b0, h_conv, h_to};
                exp_cnt = h_cnt;
            end else if (t == 1) begin
                exp_o   = 8'b1101_1000;
                exp_cnt = 0;
            end else if (t < fin_t) begin
                u       = t - 2;
                n       = u / (L + 2);
                p       = u % (L + 2);
                first   = (n == 0);
                exp_cnt = n + 1;
                if (p == 0)      exp_o = {first, first, 6'b10_1000};
                else if (p <= L) exp_o = {first, first, 6'b00_1000};
                else begin
                    exp_o  = 8'b0000_1000;
                    is_chk = 1'b1;
                end
            end else begin
                exp_o   = {6'b00_0001, conv, to};
                exp_cnt = iters;
            end
            start = (t == 0) ? 1'b1 : (glitch ? 1'($urandom_range(0, 1)) : 1'b0);
            if (is_chk) done = conv && (n == iters - 1);
            else        done = glitch ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
            check($sformatf("run%0d t%0d outs", id, t), 32'(outs()), 32'(exp_o));
            check($sformatf("run%0d t%0d cnt", id, t), 32'(iter_count), 32'(exp_cnt));
            @(posedge clk);
            #1;
        end
        start  = 1'b0;
        done   = 1'b0;
        h_conv = conv;
        h_to   = to;
        h_cnt  = iters;
    endtask

    task automatic idle_cycles(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            check($sformatf("%s c%0d outs", tag, i), 32'(outs()), 32'({6'b0, h_conv, h_to}));
            check($sformatf("%s c%0d cnt", tag, i), 32'(iter_count), 32'(h_cnt));
            @(posedge clk);
            #1;
        end
    endtask

    // Asynchronous reset from mid-cycle; outputs must clear before any clock edge.
    task automatic async_reset(input string tag);
        #2 rst = 1'b0;
        start = 1'b1;
        #1;
        check({tag, " async outs"}, 32'(outs()), 32'h0);
        check({tag, " async cnt"}, 32'(iter_count), 32'h0);
        h_conv = 1'b0;
        h_to   = 1'b0;
        h_cnt  = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("%s hold%0d", tag, i), 32'(outs()), 32'h0);
        end
        @(posedge clk);
        #1;
        rst   = 1'b1;
        start = 1'b0;
    endtask

    initial begin
        int k;
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("reset%0d outs", i), 32'(outs()), 32'h0);
            check($sformatf("reset%0d cnt", i), 32'(iter_count), 32'h0);
        end
        @(posedge clk);
        #1;
        rst   = 1'b1;
        start = 1'b0;
        idle_cycles("post_reset", 3);

        run(0, 1, 0, 1'b0);
        run(1, 3, 0, 1'b0);
        idle_cycles("idle_a", 2);
        // Back-to-back runs model start held high through IDLE.
        for (int r = 2; r < 22; r++) begin
            k = $urandom_range(1, 6);
            run(r, k, 0, 1'b1);
            if ($urandom_range(0, 1) == 1) idle_cycles($sformatf("idle_r%0d", r), 1);
        end

        // Abort in WAIT of iteration 2 (t=7 for L=2), then a clean run.
        run(30, 5, 2 + (L + 2) + 1, 1'b0);
        async_reset("abort");
        idle_cycles("after_abort", 2);
        run(31, 2, 0, 1'b1);

        // Never-converging run: times out with the macro, else 50 iterations without finish.
        run(40, 60, 2 + 50 * (L + 2), 1'b0);
        async_reset("long");
        run(41, 1, 0, 1'b0);
        idle_cycles("end", 2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/maxnet_ctrl.md
Name: maxnet_ctrl

Overview:
- Sequencing controller for the 4-neuron Maxnet datapath.
- Drives the datapath's `sel_a`, `result_signal`, `mem_en` and `ready_sig` controls.
- Issues one initial iteration from memory, then feedback iterations, until the datapath's combinational `done` (single non-zero neuron) is seen after each settled iteration.
- Reports completion, iteration count and timeout to the top-level testbench/host via a start/finish handshake.

Parameters:
- PU_LATENCY, 2, cycles from a `result_signal` pulse until PU results are stable; legal range 1..15.
- ITER_W, 8, width of the iteration counter.
- MAX_ITER, 100, iteration cap; used only when MAXNET_CTRL_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  1-cycle request to run; honoured only in IDLE.
- done  in  1  datapath convergence flag, combinational, sampled only in CHECK.
- sel_a  out  1  1 = PU inputs from memory, 0 = fed-back results.
- mem_en  out  1  memory read enable.
- result_signal  out  1  1-cycle PU compute/latch strobe.
- ready_sig  out  1  1-cycle pulse clearing the datapath done latch.
- busy  out  1  high from LOAD through CHECK.
- finish  out  1  1-cycle pulse on leaving a run.
- converged  out  1  sticky; set when the run ends with done=1.
- timeout  out  1  sticky; set when the run ends at the iteration cap.
- iter_count  out  ITER_W  iterations issued, the memory iteration counted as 1.

Behaviour:
- Reset (rst=0, async): state=IDLE; every output 0; iter_count=0; wait timer=0. Reset mid-run aborts immediately with no finish pulse.
- All outputs are registered, Moore-style from state/flags.
- IDLE: all strobes 0. On start=1, go to LOAD and clear converged, timeout and iter_count.
- LOAD (1 cycle): mem_en=1, sel_a=1, ready_sig=1. Go to FIRST.
- FIRST (1 cycle): mem_en=1, sel_a=1, result_signal=1, iter_count<=1. Go to WAIT.
- ITER (1 cycle): sel_a=0, result_signal=1, iter_count<=iter_count+1, saturating at all-ones. Go to WAIT.
- WAIT (exactly PU_LATENCY cycles): result_signal=0.
  - sel_a and mem_en hold the values of the issuing state (1/1 after FIRST, 0/0 after ITER).
  - Timer loads PU_LATENCY-1 on entry and decrements; go to CHECK at 0.
- CHECK (1 cycle): sel_a=0.
  - done=1: converged<=1, go to FINISH.
  - else if the cap is hit (see Optional Feature): timeout<=1, go to FINISH.
  - else go to ITER.
- FINISH (1 cycle): finish=1, busy=0. Go to IDLE. converged, timeout and iter_count hold until the next accepted start.
- busy=1 in LOAD, FIRST, ITER, WAIT and CHECK.
- start while busy or in FINISH is ignored; no queuing.
- start=1 held continuously restarts a run every time IDLE is reached.
- done is ignored in every state except CHECK, so glitches during PU settling have no effect.
- Latency from start (cycle 0): LOAD@1, FIRST@2, WAIT@3..2+PU_LATENCY, CHECK@3+PU_LATENCY. Each additional iteration adds PU_LATENCY+2 cycles.

Optional Feature:
- Macro: MAXNET_CTRL_TIMEOUT_EN.
- Defined: in CHECK with done=0 and iter_count>=MAX_ITER, set timeout and finish. done=1 takes priority if both conditions hold.
- Undefined: MAX_ITER is ignored, timeout is tied to 0, and the run continues until done. iter_count still saturates.

Decomposition:
- Package maxnet_ctrl_pkg holds:
  - the state encoding (IDLE, LOAD, FIRST, ITER, WAIT, CHECK, FINISH; 3-bit);
  - default constants for PU_LATENCY, ITER_W and MAX_ITER.
- One sub-module: maxnet_wait_timer, a loadable down-counter with a zero flag, used for the WAIT state.

Test Plan:
- Reset: hold rst=0 with start=1 → all outputs 0, state IDLE. Release rst → no activity until start is pulsed.
- Immediate convergence (PU_LATENCY=2, done=1 from cycle 5) → ready_sig@1; result_signal@2 only; CHECK@5; finish@6; converged=1, iter_count=1, timeout=0.
- Three iterations (done=1 only at the third CHECK) → result_signal@2,6,10; sel_a=0 from cycle 5 on; finish@14; iter_count=3.
- Timeout (macro defined, MAX_ITER=4, done=0) → 4 result_signal pulses; finish with timeout=1, converged=0, iter_count=4. Without the macro: no finish after 50 iterations.
- start pulsed during WAIT and during FINISH → ignored. After finish, a new start clears converged and restarts with LOAD.
- Reset asserted during WAIT of iteration 2 → outputs 0 asynchronously, no finish pulse. The next start runs a normal sequence with iter_count restarting at 1.
